muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 29 ++
 rtl/div_radix2.sv | 89 ++++++++
 rtl/muldiv_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op and state encodings,
// the default divider iteration count and the operand-magnitude helper.
package muldiv_ctrl_pkg;

  localparam int unsigned DivCyclesDefault = 32;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDivRun,
    StDone
  } state_e;

  // Magnitude of a value that is two's complement only when sgn is set.
  function automatic logic [31:0] abs_if(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative restoring divider: one quotient bit per cycle after start. The
// quotient/remainder outputs carry the result of the step being taken, so they
// are final in the cycle where done is high.
module div_radix2
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DivCyclesDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES) + 1;

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic [31:0] quo_step;
  logic [31:0] rem_step;

  // A borrow out of the trial subtraction means the divisor did not fit.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign quo_step  = {quo_q[30:0], ~rem_diff[32]};
  assign rem_step  = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];

  assign done      = busy_q && (cnt_q == CntW'(DIV_CYCLES - 1));
  assign quotient  = q_neg_q ? (32'd0 - quo_step) : quo_step;
  assign remainder = r_neg_q ? (32'd0 - rem_step) : rem_step;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      quo_d   = abs_if(is_signed, dividend);
      rem_d   = '0;
      dvs_d   = abs_if(is_signed, divisor);
      q_neg_d = is_signed && (dividend[31] ^ divisor[31]);
      r_neg_d = is_signed && dividend[31];
    end else if (busy_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + CntW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO unit sequencer: multi-cycle MULT/DIV with pipeline stall, MTHI/MTLO,
// flush and external-stall handling. Owns the multiplier and HI/LO registers.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DivCyclesDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ext_stall,
  input  logic        flush,
  output logic        stall_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        mul_signed_q, mul_signed_d;
  logic        div_zero_q, div_zero_d;

  op_e         op_in;
  logic        is_mul, is_div, div_start, div_done;
  logic [31:0] div_quo, div_rem;
  logic [63:0] product;

  assign op_in     = op_e'(op);
  assign is_mul    = op_valid && ((op_in == OpMult) || (op_in == OpMultu));
  assign is_div    = op_valid && ((op_in == OpDiv) || (op_in == OpDivu));
  assign div_start = (state_q == StIdle) && is_div && !flush;

  // Low 64 bits of the product of the 64-bit extensions equal the signed/unsigned product.
  assign product = {{32{mul_signed_q & a_q[31]}}, a_q} * {{32{mul_signed_q & b_q[31]}}, b_q};

  div_radix2 #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .is_signed(op_in == OpDiv),
    .dividend (src_a),
    .divisor  (src_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    a_d          = a_q;
    b_d          = b_q;
    mul_signed_d = mul_signed_q;
    div_zero_d   = 1'b0;
    stall_out    = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_mul || is_div) begin
            stall_out    = 1'b1;
            state_d      = is_mul ? StMul : StDivRun;
            a_d          = src_a;
            b_d          = src_b;
            mul_signed_d = (op_in == OpMult);
          end else if (op_valid && !ext_stall && (op_in == OpMthi)) begin
            hi_d = src_a;
          end else if (op_valid && !ext_stall && (op_in == OpMtlo)) begin
            lo_d = src_a;
          end
        end
        StMul: begin
          stall_out    = 1'b1;
          {hi_d, lo_d} = product;
          state_d      = StDone;
        end
        StDivRun: begin
          stall_out = 1'b1;
          if (div_done) begin
            state_d = StDone;
            if (b_q == 32'd0) begin
              hi_d       = a_q;
              lo_d       = 32'hFFFF_FFFF;
              div_zero_d = 1'b1;
            end else begin
              hi_d = div_rem;
              lo_d = div_quo;
            end
          end
        end
        StDone: begin
          // The finished instruction may still sit in EXE while frozen; never restart it.
          if (!ext_stall) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      hi_q         <= '0;
      lo_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mul_signed_q <= mul_signed_d;
      div_zero_q   <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule
